wb_bus_matrix: RTL
==================

// Module: wb_bus_matrix
// PURPOSE
//  Parametrised shared-bus Wishbone interconnect: N_MST masters arbitrate round-robin for one bus.
//  The bus is address-decoded to N_SLV slaves. Unmapped or hung accesses terminate with ERR.
//  Sits between CPU ifetch/LSU/DMA masters and the memory/peripheral slaves in the SoC top.
// PARAMETERS
//  N_MST     2                     number of masters (1..8)
//  N_SLV     6                     number of slaves (1..16)
//  SLV_BASE  {N_SLV{32'h0}}        packed N_SLV*32; slave k base = SLV_BASE[32k+:32]
//  SLV_MASK  {N_SLV{32'hFFFF0000}} packed N_SLV*32; slave k hit when (adr & mask_k) == base_k
//  TIMEOUT   255                   cycles without ACK/ERR before forced ERR; 0 disables
// PORTS
//  i_clk     in   1            clock, rising edge
//  i_rstn    in   1            asynchronous active-low reset
//  i_m2s_wb  in   N_MST*M2S_W  master requests; master j at [M2S_W*j+:M2S_W]
//  o_s2m_wb  out  N_MST*S2M_W  responses to masters
//  o_m2s_wb  out  N_SLV*M2S_W  requests to slaves
//  i_s2m_wb  in   N_SLV*S2M_W  slave responses
//  o_grant   out  N_MST        one-hot current bus owner, 0 when idle
//  o_bus_err out  1            1-cycle pulse on each decode-miss or timeout ERR
// BEHAVIOUR
//  Reset: state=IDLE, o_grant=0, rr pointer=0, timeout cnt=0, o_bus_err=0;
//   all o_m2s cyc/stb=0, all o_s2m ack/err=0 (comb outputs follow grant=0).
//  FSM IDLE -> BUSY: any master cyc=1. Grant registered, so 1 cycle arbitration latency.
//   Winner = first requester at or after rr pointer (wrapping). On grant, pointer = winner+1 mod N_MST.
//  BUSY: grant held while owner cyc=1 (bus lock; covers multi-beat / RMW cycles).
//   Owner cyc=0 -> IDLE, grant cleared same edge. Re-arbitration needs one IDLE cycle.
//  BUSY -> ERR: owner stb=1 with no slave hit, or timeout cnt == TIMEOUT-1 while stb=1 and no ack/err.
//   ERR lasts exactly 1 cycle: owner err=1, ack=0, o_bus_err=1. Then BUSY if owner cyc=1, else IDLE.
//  Decode: combinational on owner adr. Lowest index wins on overlapping windows.
//   Only the hit slave sees cyc/stb. All slaves see adr/dat/sel/we of the owner.
//  Response path: owner's o_s2m = hit slave's dat/ack/err (zero-latency comb route).
//   Non-owners get ack=err=0, dat=0.
//  Timeout cnt: cleared on ack, err, or stb=0; increments while owner stb=1 in BUSY.
//   Width $clog2(TIMEOUT+1). No wrap: saturates at TIMEOUT-1.
//  Simultaneous requests: resolved by rr pointer only. Starvation-free: a waiting master wins within N_MST grants.
//  Owner drops cyc while slave ack arrives: ack still forwarded that cycle; next cycle IDLE.
//  Slave ack and timeout in the same cycle: ack wins, no ERR.
//  Reset mid-transfer: all outputs to reset values immediately (async); in-flight transfer abandoned.
//  N_MST==1: arbiter degenerates; grant still registered, same latency.
// STRUCTURE
//  Shared package (extended): WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4.
//   M2S_W=72 as {adr,dat,sel,we,cyc,stb}; S2M_W=34 as {dat,ack,err}.
//   Field offset localparams; FSM state encodings (IDLE=2'd0, BUSY=2'd1, ERR=2'd2).
//  Sub-module wb_rr_arbiter #(N): req[N], advance -> one-hot gnt[N]; holds the rr pointer.
//   Reused by future multi-layer interconnect.
//  Decoder, FSM, timeout counter, muxes stay in wb_bus_matrix (generate loops).
// TESTING
//  1 N_MST=2 N_SLV=6, M0 read 0x0001_0004 -> grant=01 after 1 clk; only slave1 stb; M0 gets slave1 dat+ack.
//  2 M0,M1 cyc same cycle, rr=0 -> M0 granted.
//    M0 drops cyc; both re-request -> M1 granted; alternation holds for 8 transfers.
//  3 M1 access 0xDEAD_0000 (unmapped) -> no slave stb; M1 err=1 for exactly 1 clk; o_bus_err pulse.
//  4 TIMEOUT=4, slave2 never acks -> err on 4th stb cycle; a later ack from slave2 in the same cycle
//    suppresses err.
//  5 M0 holds cyc over 3 stb beats while M1 requests -> M1 waits; granted 2 clk after M0 cyc falls.
//  6 Assert i_rstn=0 mid-BUSY (between edges) -> o_grant=0 and all cyc/stb=0 before next edge;
//    rr pointer=0 after release.

Source files
------------

// File: rtl/wb_bus_matrix_pkg.sv
// Shared Wishbone field layout, widths and interconnect FSM encodings.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package wb_bus_matrix_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Request word {rsvd, adr, dat, sel, we, cyc, stb}; bit 71 is a spare bit.
  localparam int M2S_W   = 72;
  localparam int M2S_STB = 0;
  localparam int M2S_CYC = 1;
  localparam int M2S_WE  = 2;
  localparam int M2S_SEL = 3;
  localparam int M2S_DAT = M2S_SEL + WB_SEL_W;
  localparam int M2S_ADR = M2S_DAT + WB_DAT_W;

  // Response word {dat, ack, err}.
  localparam int S2M_W   = 34;
  localparam int S2M_ERR = 0;
  localparam int S2M_ACK = 1;
  localparam int S2M_DAT = 2;

  typedef struct packed {
    logic                rsvd;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
    logic                we;
    logic                cyc;
    logic                stb;
  } m2s_t;

  typedef struct packed {
    logic [WB_DAT_W-1:0] dat;
    logic                ack;
    logic                err;
  } s2m_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/wb_bus_matrix_if.sv
// Bundled request/response buses between masters, the matrix and slaves.
// Latency: none (wiring only).
// Backpressure: none here; Wishbone ack/err carried inside the response words.
interface wb_bus_matrix_if #(
  parameter int N_MST = 2,
  parameter int N_SLV = 6
);
  import wb_bus_matrix_pkg::*;

  logic [N_MST*M2S_W-1:0] i_m2s_wb;  // master requests into the matrix
  logic [N_MST*S2M_W-1:0] o_s2m_wb;  // responses back to masters
  logic [N_SLV*M2S_W-1:0] o_m2s_wb;  // requests out to slaves
  logic [N_SLV*S2M_W-1:0] i_s2m_wb;  // slave responses into the matrix

  // Seen from the interconnect.
  modport slave (
    input  i_m2s_wb,
    output o_s2m_wb,
    output o_m2s_wb,
    input  i_s2m_wb
  );

  // Seen from the masters/slaves surrounding the interconnect.
  modport master (
    output i_m2s_wb,
    input  o_s2m_wb,
    input  o_m2s_wb,
    output i_s2m_wb
  );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant of first requester at/after pointer.
// Latency: grant is combinational; pointer moves on the edge where i_advance is high.
// Backpressure: none; caller decides when a grant is taken via i_advance.
module wb_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic             found;

  // Search upward from the pointer first, then wrap to the bottom.
  always_comb begin
    o_gnt = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && i_req[i] && (i >= int'(ptr_q))) begin
        found    = 1'b1;
        o_gnt[i] = 1'b1;
        ptr_d    = (i == N - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && i_req[i]) begin
        found    = 1'b1;
        o_gnt[i] = 1'b1;
        ptr_d    = (i == N - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // Pointer steps past the winner only when the grant is actually taken.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr_q <= '0;
    end else if (i_advance) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wb_bus_matrix.sv
// Shared-bus Wishbone interconnect: RR arbitration, address decode, ERR on miss/timeout.
// Latency: 1 clk arbitration, then zero-latency comb request/response routing.
// Backpressure: owner is held on the bus until it drops cyc; others wait for an IDLE cycle.
module wb_bus_matrix
  import wb_bus_matrix_pkg::*;
#(
  parameter int                   N_MST    = 2,
  parameter int                   N_SLV    = 6,
  parameter logic [N_SLV*32-1:0]  SLV_BASE = {N_SLV{32'h0}},
  parameter logic [N_SLV*32-1:0]  SLV_MASK = {N_SLV{32'hFFFF0000}},
  parameter int                   TIMEOUT  = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  wb_bus_matrix_if.slave        bus,
  output logic [N_MST-1:0]      o_grant,
  output logic                  o_bus_err
);

  localparam int                CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e            state_q;
  logic [N_MST-1:0]  grant_q;
  logic              bus_err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  m2s_t              mst     [N_MST];
  s2m_t              slv     [N_SLV];
  m2s_t              slv_req [N_SLV];
  s2m_t              mst_rsp [N_MST];
  m2s_t              own;
  s2m_t              rsp;
  logic [N_MST-1:0]  req;
  logic [N_MST-1:0]  arb_gnt;
  logic              arb_adv;
  logic [N_SLV-1:0]  hit_oh;
  logic              hit;
  logic              busy;
  logic              to_hit;

  for (genvar j = 0; j < N_MST; j++) begin : g_mst
    assign mst[j] = m2s_t'(bus.i_m2s_wb[M2S_W*j +: M2S_W]);
    assign req[j] = mst[j].cyc;
    assign bus.o_s2m_wb[S2M_W*j +: S2M_W] = mst_rsp[j];
  end

  for (genvar k = 0; k < N_SLV; k++) begin : g_slv
    assign slv[k] = s2m_t'(bus.i_s2m_wb[S2M_W*k +: S2M_W]);
    assign bus.o_m2s_wb[M2S_W*k +: M2S_W] = slv_req[k];
  end

  assign busy    = (state_q == ST_BUSY);
  assign arb_adv = (state_q == ST_IDLE) && (|req);

  wb_rr_arbiter #(.N(N_MST)) u_arb (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_req     (req),
    .i_advance (arb_adv),
    .o_gnt     (arb_gnt)
  );

  // Select the current owner's request (grant is one-hot or zero).
  always_comb begin
    own = '0;
    for (int j = 0; j < N_MST; j++) begin
      if (grant_q[j]) own = mst[j];
    end
  end

  // Address decode on the owner's address; lowest slave index wins overlaps.
  always_comb begin
    hit_oh = '0;
    hit    = 1'b0;
    for (int k = 0; k < N_SLV; k++) begin
      if (!hit && ((own.adr & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32])) begin
        hit_oh[k] = 1'b1;
        hit       = 1'b1;
      end
    end
  end

  // Broadcast adr/dat/sel/we; only the decoded slave gets cyc/stb, and only while BUSY.
  always_comb begin
    for (int k = 0; k < N_SLV; k++) begin
      slv_req[k]     = own;
      slv_req[k].cyc = own.cyc & hit_oh[k] & busy;
      slv_req[k].stb = own.stb & hit_oh[k] & busy;
    end
  end

  // Route the decoded slave's response back; ERR state injects the error response.
  always_comb begin
    rsp = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (hit_oh[k]) rsp = slv[k];
    end
    for (int j = 0; j < N_MST; j++) begin
      mst_rsp[j] = '0;
      if (grant_q[j]) begin
        if (busy) begin
          mst_rsp[j] = rsp;
        end else if (state_q == ST_ERR) begin
          mst_rsp[j].err = 1'b1;
        end
      end
    end
  end

  // Hang watchdog: counts unanswered strobe cycles, saturating at the last allowed cycle.
  always_comb begin
    to_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST) && own.stb && !rsp.ack && !rsp.err;
    cnt_d  = cnt_q;
    if (!busy || !own.stb || rsp.ack || rsp.err) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Bus ownership FSM with registered grant, error pulse and timeout count.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      bus_err_q <= 1'b0;
      cnt_q     <= cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q <= ST_BUSY;
            grant_q <= arb_gnt;
          end
        end
        ST_BUSY: begin
          if (!own.cyc) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
          end else if (own.stb && (!hit || to_hit)) begin
            state_q   <= ST_ERR;
            bus_err_q <= 1'b1;
          end
        end
        ST_ERR: begin
          if (own.cyc) begin
            state_q <= ST_BUSY;
          end else begin
            state_q <= ST_IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign o_grant   = grant_q;
  assign o_bus_err = bus_err_q;

endmodule
